// File: rtl/c_pkg.sv
`default_nettype none
// ============================================================================
// Module  : c_pkg
// Brief   : Shared constants and types for the RVC expand stage: base
//           opcodes, RVC quadrant/funct3 codes, the canonical NOP and the
//           entry format held in the skid buffer.
// Revision: 1.0 - initial release
// ============================================================================
package c_pkg;

    // Base RV32I major opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // RVC quadrants (inst[1:0]); Q3 marks a full 32-bit instruction
    localparam logic [1:0] Q0 = 2'b00;
    localparam logic [1:0] Q1 = 2'b01;
    localparam logic [1:0] Q2 = 2'b10;
    localparam logic [1:0] Q3 = 2'b11;

    // Quadrant 0 funct3 (inst[15:13])
    localparam logic [2:0] F3_ADDI4SPN = 3'b000;
    localparam logic [2:0] F3_LW       = 3'b010;
    localparam logic [2:0] F3_SW       = 3'b110;

    // Quadrant 1 funct3
    localparam logic [2:0] F3_ADDI     = 3'b000;
    localparam logic [2:0] F3_JAL      = 3'b001;
    localparam logic [2:0] F3_LI       = 3'b010;
    localparam logic [2:0] F3_LUI      = 3'b011;
    localparam logic [2:0] F3_MISC_ALU = 3'b100;
    localparam logic [2:0] F3_J        = 3'b101;
    localparam logic [2:0] F3_BEQZ     = 3'b110;
    localparam logic [2:0] F3_BNEZ     = 3'b111;

    // Quadrant 2 funct3
    localparam logic [2:0] F3_SLLI     = 3'b000;
    localparam logic [2:0] F3_LWSP     = 3'b010;
    localparam logic [2:0] F3_JR_MV    = 3'b100;
    localparam logic [2:0] F3_SWSP     = 3'b110;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        is_compressed;
        logic        illegal;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/c_expander.sv
`default_nettype none
// ============================================================================
// Module  : c_expander
// Brief   : Combinational RV32C -> RV32I expander. Reserved/illegal and
//           floating-point encodings flag o_illegal and return the raw
//           halfword zero-extended.
// Revision: 1.0 - initial release
// ============================================================================
module c_expander
    import c_pkg::*;
(
    input  logic [15:0] i_inst,
    output logic [31:0] o_inst,
    output logic        o_illegal
);

    logic [1:0]  w_quad;
    logic [2:0]  w_f3;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rdp;
    logic [4:0]  w_rs1p;
    logic [11:0] w_imm_ci;
    logic [11:0] w_imm_4spn;
    logic [11:0] w_imm_lw;
    logic [11:0] w_imm_16sp;
    logic [11:0] w_imm_lwsp;
    logic [11:0] w_imm_swsp;
    logic [20:0] w_imm_j;
    logic [12:0] w_imm_b;
    logic [31:0] w_exp;
    logic        w_ill;

    assign w_quad = i_inst[1:0];
    assign w_f3   = i_inst[15:13];
    assign w_rd   = i_inst[11:7];
    assign w_rs2  = i_inst[6:2];
    // Compressed register fields address x8..x15
    assign w_rdp  = {2'b01, i_inst[4:2]};
    assign w_rs1p = {2'b01, i_inst[9:7]};

    // Immediates unscrambled into their natural bit order
    assign w_imm_ci   = {{6{i_inst[12]}}, i_inst[12], i_inst[6:2]};
    assign w_imm_4spn = {2'b00, i_inst[10:7], i_inst[12:11], i_inst[5], i_inst[6], 2'b00};
    assign w_imm_lw   = {5'b00000, i_inst[5], i_inst[12:10], i_inst[6], 2'b00};
    assign w_imm_16sp = {{3{i_inst[12]}}, i_inst[4:3], i_inst[5], i_inst[2], i_inst[6], 4'b0000};
    assign w_imm_lwsp = {4'b0000, i_inst[3:2], i_inst[12], i_inst[6:4], 2'b00};
    assign w_imm_swsp = {4'b0000, i_inst[8:7], i_inst[12:9], 2'b00};
    assign w_imm_j    = {{10{i_inst[12]}}, i_inst[8], i_inst[10:9], i_inst[6], i_inst[7],
                         i_inst[2], i_inst[11], i_inst[5:3], 1'b0};
    assign w_imm_b    = {{5{i_inst[12]}}, i_inst[6:5], i_inst[2], i_inst[11:10], i_inst[4:3], 1'b0};

    // Decode the halfword by quadrant and funct3 into its RV32I form
    always_comb begin
        w_exp = {16'h0000, i_inst};
        w_ill = 1'b0;
        case (w_quad)
            Q0: begin
                case (w_f3)
                    F3_ADDI4SPN: begin
                        w_exp = {w_imm_4spn, 5'd2, 3'b000, w_rdp, OP_IMM};
                        w_ill = (i_inst[12:5] == 8'h00);
                    end
                    F3_LW: w_exp = {w_imm_lw, w_rs1p, 3'b010, w_rdp, OP_LOAD};
                    F3_SW: w_exp = {w_imm_lw[11:5], w_rdp, w_rs1p, 3'b010, w_imm_lw[4:0], OP_STORE};
                    default: w_ill = 1'b1;   // FP loads/stores and reserved
                endcase
            end
            Q1: begin
                case (w_f3)
                    F3_ADDI: w_exp = {w_imm_ci, w_rd, 3'b000, w_rd, OP_IMM};
                    F3_JAL:  w_exp = {w_imm_j[20], w_imm_j[10:1], w_imm_j[11], w_imm_j[19:12], 5'd1, OP_JAL};
                    F3_LI:   w_exp = {w_imm_ci, 5'd0, 3'b000, w_rd, OP_IMM};
                    F3_LUI: begin
                        if (w_rd == 5'd2)
                            w_exp = {w_imm_16sp, 5'd2, 3'b000, 5'd2, OP_IMM};
                        else
                            w_exp = {{14{i_inst[12]}}, i_inst[12], i_inst[6:2], w_rd, OP_LUI};
                        w_ill = ~i_inst[12] & (i_inst[6:2] == 5'd0);
                    end
                    F3_MISC_ALU: begin
                        case (i_inst[11:10])
                            2'b00: begin
                                w_exp = {7'b0000000, i_inst[6:2], w_rs1p, 3'b101, w_rs1p, OP_IMM};
                                w_ill = i_inst[12];
                            end
                            2'b01: begin
                                w_exp = {7'b0100000, i_inst[6:2], w_rs1p, 3'b101, w_rs1p, OP_IMM};
                                w_ill = i_inst[12];
                            end
                            2'b10: w_exp = {w_imm_ci, w_rs1p, 3'b111, w_rs1p, OP_IMM};
                            default: begin
                                // inst[12]=1 selects SUBW/ADDW, reserved on RV32
                                w_ill = i_inst[12];
                                case (i_inst[6:5])
                                    2'b00:   w_exp = {7'b0100000, w_rdp, w_rs1p, 3'b000, w_rs1p, OP_OP};
                                    2'b01:   w_exp = {7'b0000000, w_rdp, w_rs1p, 3'b100, w_rs1p, OP_OP};
                                    2'b10:   w_exp = {7'b0000000, w_rdp, w_rs1p, 3'b110, w_rs1p, OP_OP};
                                    default: w_exp = {7'b0000000, w_rdp, w_rs1p, 3'b111, w_rs1p, OP_OP};
                                endcase
                            end
                        endcase
                    end
                    F3_J:    w_exp = {w_imm_j[20], w_imm_j[10:1], w_imm_j[11], w_imm_j[19:12], 5'd0, OP_JAL};
                    F3_BEQZ: w_exp = {w_imm_b[12], w_imm_b[10:5], 5'd0, w_rs1p, 3'b000,
                                      w_imm_b[4:1], w_imm_b[11], OP_BRANCH};
                    default: w_exp = {w_imm_b[12], w_imm_b[10:5], 5'd0, w_rs1p, 3'b001,
                                      w_imm_b[4:1], w_imm_b[11], OP_BRANCH};
                endcase
            end
            Q2: begin
                case (w_f3)
                    F3_SLLI: begin
                        w_exp = {7'b0000000, i_inst[6:2], w_rd, 3'b001, w_rd, OP_IMM};
                        w_ill = i_inst[12];
                    end
                    F3_LWSP: begin
                        w_exp = {w_imm_lwsp, 5'd2, 3'b010, w_rd, OP_LOAD};
                        w_ill = (w_rd == 5'd0);
                    end
                    F3_JR_MV: begin
                        if (!i_inst[12]) begin
                            if (w_rs2 == 5'd0) begin
                                w_exp = {12'h000, w_rd, 3'b000, 5'd0, OP_JALR};
                                w_ill = (w_rd == 5'd0);
                            end else begin
                                w_exp = {7'b0000000, w_rs2, 5'd0, 3'b000, w_rd, OP_OP};
                            end
                        end else begin
                            if (w_rs2 != 5'd0)
                                w_exp = {7'b0000000, w_rs2, w_rd, 3'b000, w_rd, OP_OP};
                            else if (w_rd == 5'd0)
                                w_exp = {12'h001, 5'd0, 3'b000, 5'd0, OP_SYSTEM};
                            else
                                w_exp = {12'h000, w_rd, 3'b000, 5'd1, OP_JALR};
                        end
                    end
                    F3_SWSP: w_exp = {w_imm_swsp[11:5], w_rs2, 5'd2, 3'b010, w_imm_swsp[4:0], OP_STORE};
                    default: w_ill = 1'b1;   // FP stack loads/stores
                endcase
            end
            default: ;   // full-width instruction, bypassed by the stage
        endcase
    end

    assign o_inst    = w_ill ? {16'h0000, i_inst} : w_exp;
    assign o_illegal = w_ill;

endmodule
`default_nettype wire

// File: rtl/c_expand_stage.sv
`default_nettype none
// ============================================================================
// Module  : c_expand_stage
// Brief   : Fetch-to-decode stage. Expands RVC instructions and registers
//           them with PC and flags through a 2-entry skid buffer with a
//           registered in_ready and a branch flush.
// Revision: 1.0 - initial release
// ============================================================================
module c_expand_stage
    import c_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  inst_in,
    input  logic [XLEN-1:0]  pc_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  inst_out,
    output logic [XLEN-1:0]  pc_out,
    output logic             is_compressed_o,
    output logic             illegal_o
);

    localparam fetch_entry_t RESET_ENTRY = '{inst: NOP, pc: RESET_PC,
                                             is_compressed: 1'b0, illegal: 1'b0};

    logic [31:0]   w_exp_inst;
    logic          w_exp_ill;
    logic          w_is_c;
    fetch_entry_t  w_new;
    logic          w_in_fire;
    logic          w_out_fire;

    fetch_entry_t  r_out;     // entry 0: drives the outputs
    fetch_entry_t  r_skid;    // entry 1: holds overflow while stalled
    logic [1:0]    r_count;
    logic          r_in_ready;

    fetch_entry_t  w_out_n;
    fetch_entry_t  w_skid_n;
    logic [1:0]    w_count_n;

    c_expander u_expander (
        .i_inst    (inst_in[15:0]),
        .o_inst    (w_exp_inst),
        .o_illegal (w_exp_ill)
    );

    assign w_is_c     = (inst_in[1:0] != Q3);
    assign w_new.inst = w_is_c ? w_exp_inst : inst_in;
    assign w_new.pc   = pc_in;
    assign w_new.is_compressed = w_is_c;
    assign w_new.illegal       = w_is_c & w_exp_ill;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = (r_count != 2'd0) & out_ready;

    // Skid-buffer next state: flush wins, otherwise FIFO push/pop by occupancy
    always_comb begin
        w_out_n   = r_out;
        w_skid_n  = r_skid;
        w_count_n = r_count;
        if (flush) begin
            w_count_n = 2'd0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (w_in_fire) begin
                        w_out_n   = w_new;
                        w_count_n = 2'd1;
                    end
                end
                2'd1: begin
                    if (w_in_fire && w_out_fire) begin
                        w_out_n = w_new;
                    end else if (w_in_fire) begin
                        w_skid_n  = w_new;
                        w_count_n = 2'd2;
                    end else if (w_out_fire) begin
                        w_count_n = 2'd0;
                    end
                end
                default: begin
                    // in_ready is low when full, so only a drain can happen
                    if (w_out_fire) begin
                        w_out_n   = r_skid;
                        w_count_n = 2'd1;
                    end
                end
            endcase
        end
    end

    // Buffer state and the look-ahead ready flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out      <= RESET_ENTRY;
            r_skid     <= RESET_ENTRY;
            r_count    <= 2'd0;
            r_in_ready <= 1'b1;
        end else begin
            r_out      <= w_out_n;
            r_skid     <= w_skid_n;
            r_count    <= w_count_n;
            r_in_ready <= (w_count_n != 2'd2);
        end
    end

    assign in_ready        = r_in_ready;
    assign out_valid       = (r_count != 2'd0);
    assign inst_out        = r_out.inst;
    assign pc_out          = r_out.pc;
    assign is_compressed_o = r_out.is_compressed;
    assign illegal_o       = r_out.illegal;

endmodule
`default_nettype wire

// File: tb/tb_c_expand_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_c_expand_stage
// Brief   : Self-checking bench for c_expand_stage: directed vectors plus
//           randomized traffic against a queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_c_expand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inst_in;
    logic [31:0] pc_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        is_compressed_o;
    logic        illegal_o;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        c;
        logic        ill;
    } exp_t;

    exp_t q[$];
    exp_t shown;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    c_expand_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .inst_in         (inst_in),
        .pc_in           (pc_in),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .inst_out        (inst_out),
        .pc_out          (pc_out),
        .is_compressed_o (is_compressed_o),
        .illegal_o       (illegal_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- instruction field encoders ----------------
    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
        logic [31:0] m, a, f, d, o;
        m = imm; a = rs1; f = f3; d = rd; o = op;
        return {m[11:0], a[4:0], f[2:0], d[4:0], o[6:0]};
    endfunction

    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3, int op);
        logic [31:0] m, b, a, f, o;
        m = imm; b = rs2; a = rs1; f = f3; o = op;
        return {m[11:5], b[4:0], a[4:0], f[2:0], m[4:0], o[6:0]};
    endfunction

    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd, int op);
        logic [31:0] s, b, a, f, d, o;
        s = f7; b = rs2; a = rs1; f = f3; d = rd; o = op;
        return {s[6:0], b[4:0], a[4:0], f[2:0], d[4:0], o[6:0]};
    endfunction

    function automatic logic [31:0] enc_b(int off, int rs1, int f3);
        logic [31:0] m, a, f;
        m = off; a = rs1; f = f3;
        return {m[12], m[10:5], 5'd0, a[4:0], f[2:0], m[4:1], m[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(int off, int rd);
        logic [31:0] m, d;
        m = off; d = rd;
        return {m[20], m[10:1], m[11], m[19:12], d[4:0], 7'h6f};
    endfunction

    function automatic logic [31:0] enc_u(int upper, int rd);
        logic [31:0] m, d;
        m = upper; d = rd;
        return {m[19:0], d[4:0], 7'h37};
    endfunction

    // ---------------- RVC semantics: {illegal, rv32i} ----------------
    function automatic logic [32:0] ref_expand(input logic [15:0] c);
        int   qd, f, rd, rs2, rdp, rs1p, ci, imm, off, sh;
        logic ill;
        logic [31:0] r;
        qd = int'(c[1:0]); f = int'(c[15:13]);
        rd = int'(c[11:7]); rs2 = int'(c[6:2]);
        rdp = 8 + int'(c[4:2]); rs1p = 8 + int'(c[9:7]);
        ci = int'(c[6:2]) + (c[12] ? 32 : 0);
        if (c[12]) ci = ci - 64;
        sh = int'(c[6:2]);
        ill = 1'b0; r = 32'h0;
        if (qd == 0) begin
            imm = int'(c[12:10]) * 8 + int'(c[6]) * 4 + int'(c[5]) * 64;
            if (f == 0) begin
                imm = int'(c[12:11]) * 16 + int'(c[10:7]) * 64 + int'(c[6]) * 4 + int'(c[5]) * 8;
                ill = (imm == 0);
                r = enc_i(imm, 2, 0, rdp, 'h13);
            end else if (f == 2) r = enc_i(imm, rs1p, 2, rdp, 'h03);
            else if (f == 6) r = enc_s(imm, rdp, rs1p, 2, 'h23);
            else ill = 1'b1;
        end else if (qd == 1) begin
            off = int'(c[12]) * 2048 + int'(c[11]) * 16 + int'(c[10:9]) * 256 + int'(c[8]) * 1024
                + int'(c[7]) * 64 + int'(c[6]) * 128 + int'(c[5:3]) * 2 + int'(c[2]) * 32;
            if (c[12]) off = off - 4096;
            case (f)
                0: r = enc_i(ci, rd, 0, rd, 'h13);
                1: r = enc_j(off, 1);
                2: r = enc_i(ci, 0, 0, rd, 'h13);
                3: begin
                    ill = (ci == 0);
                    if (rd == 2) begin
                        imm = int'(c[12]) * 512 + int'(c[4:3]) * 128 + int'(c[5]) * 64
                            + int'(c[2]) * 32 + int'(c[6]) * 16;
                        if (c[12]) imm = imm - 1024;
                        r = enc_i(imm, 2, 0, 2, 'h13);
                    end else begin
                        r = enc_u(ci, rd);
                    end
                end
                4: begin
                    case (int'(c[11:10]))
                        0: begin ill = c[12]; r = enc_r(0, sh, rs1p, 5, rs1p, 'h13); end
                        1: begin ill = c[12]; r = enc_r('h20, sh, rs1p, 5, rs1p, 'h13); end
                        2: r = enc_i(ci, rs1p, 7, rs1p, 'h13);
                        default: begin
                            ill = c[12];
                            case (int'(c[6:5]))
                                0: r = enc_r('h20, rdp, rs1p, 0, rs1p, 'h33);
                                1: r = enc_r(0, rdp, rs1p, 4, rs1p, 'h33);
                                2: r = enc_r(0, rdp, rs1p, 6, rs1p, 'h33);
                                default: r = enc_r(0, rdp, rs1p, 7, rs1p, 'h33);
                            endcase
                        end
                    endcase
                end
                5: r = enc_j(off, 0);
                default: begin
                    off = int'(c[12]) * 256 + int'(c[6:5]) * 64 + int'(c[2]) * 32
                        + int'(c[11:10]) * 8 + int'(c[4:3]) * 2;
                    if (c[12]) off = off - 512;
                    r = enc_b(off, rs1p, f - 6);
                end
            endcase
        end else begin
            case (f)
                0: begin ill = c[12]; r = enc_r(0, sh, rd, 1, rd, 'h13); end
                2: begin
                    ill = (rd == 0);
                    imm = int'(c[12]) * 32 + int'(c[6:4]) * 4 + int'(c[3:2]) * 64;
                    r = enc_i(imm, 2, 2, rd, 'h03);
                end
                4: begin
                    if (!c[12]) begin
                        if (rs2 == 0) begin ill = (rd == 0); r = enc_i(0, rd, 0, 0, 'h67); end
                        else r = enc_r(0, rs2, 0, 0, rd, 'h33);
                    end else begin
                        if (rs2 != 0) r = enc_r(0, rs2, rd, 0, rd, 'h33);
                        else if (rd == 0) r = 32'h0010_0073;
                        else r = enc_i(0, rd, 0, 1, 'h67);
                    end
                end
                6: begin
                    imm = int'(c[12:9]) * 4 + int'(c[8:7]) * 64;
                    r = enc_s(imm, rs2, 2, 2, 'h23);
                end
                default: ill = 1'b1;
            endcase
        end
        return {ill, r};
    endfunction

    function automatic exp_t model_entry(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        logic [32:0] x;
        e.pc = pc;
        if (ins[1:0] == 2'b11) begin
            e.inst = ins; e.c = 1'b0; e.ill = 1'b0;
        end else begin
            x = ref_expand(ins[15:0]);
            e.c = 1'b1; e.ill = x[32];
            e.inst = x[32] ? {16'h0000, ins[15:0]} : x[31:0];
        end
        return e;
    endfunction

    function automatic exp_t reset_entry();
        exp_t e;
        e.inst = 32'h0000_0013; e.pc = 32'h0; e.c = 1'b0; e.ill = 1'b0;
        return e;
    endfunction

    // Called just after a falling edge: check outputs, drive inputs,
    // advance the model to the next rising edge, then wait one cycle.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ordy, input logic fl);
        logic acc;
        check_eq("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
        check_eq("in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
        check_eq("inst_out", inst_out, shown.inst);
        check_eq("pc_out", pc_out, shown.pc);
        check_eq("is_compressed", {31'b0, is_compressed_o}, {31'b0, shown.c});
        check_eq("illegal", {31'b0, illegal_o}, {31'b0, shown.ill});
        in_valid = v; inst_in = ins; pc_in = pc; out_ready = ordy; flush = fl;
        if (fl) begin
            q.delete();
        end else begin
            acc = v && (q.size() < 2);
            if (q.size() != 0 && ordy) void'(q.pop_front());
            if (acc) q.push_back(model_entry(ins, pc));
        end
        if (q.size() != 0) shown = q[0];
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] r;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        inst_in = 32'h0; pc_in = 32'h0;
        shown = reset_entry();
        #2 reset = 1'b0;
        #1;
        check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check_eq("rst_inst_out", inst_out, 32'h0000_0013);
        check_eq("rst_pc_out", pc_out, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Directed expansions
        step(1'b1, 32'h0000_4104, 32'h0, 1'b1, 1'b0);
        check_eq("tp_lw", inst_out, 32'h0005_2483);
        check_eq("tp_lw_c", {31'b0, is_compressed_o}, 32'd1);
        check_eq("tp_lw_valid", {31'b0, out_valid}, 32'd1);
        step(1'b1, 32'h0000_4505, 32'h2, 1'b1, 1'b0);
        check_eq("tp_li", inst_out, 32'h0010_0513);
        step(1'b1, 32'h0000_0001, 32'h4, 1'b1, 1'b0);
        check_eq("tp_nop", inst_out, 32'h0000_0013);
        step(1'b1, 32'h0050_0093, 32'h6, 1'b1, 1'b0);
        check_eq("tp_addi", inst_out, 32'h0050_0093);
        check_eq("tp_addi_c", {31'b0, is_compressed_o}, 32'd0);
        step(1'b1, 32'h0000_0000, 32'ha, 1'b1, 1'b0);
        check_eq("tp_zero_ill", {31'b0, illegal_o}, 32'd1);
        check_eq("tp_zero_inst", inst_out, 32'h0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Backpressure: third input held until a drain
        step(1'b1, 32'h0000_4505, 32'h100, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0001, 32'h104, 1'b0, 1'b0);
        check_eq("bp_full_ready", {31'b0, in_ready}, 32'd0);
        step(1'b1, 32'h0050_0093, 32'h108, 1'b0, 1'b0);
        check_eq("bp_hold_pc", pc_out, 32'h100);
        step(1'b1, 32'h0050_0093, 32'h108, 1'b1, 1'b0);
        check_eq("bp_drain1_pc", pc_out, 32'h104);
        check_eq("bp_ready_back", {31'b0, in_ready}, 32'd1);
        step(1'b1, 32'h0050_0093, 32'h108, 1'b1, 1'b0);
        check_eq("bp_third_pc", pc_out, 32'h108);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush at full and at single occupancy
        step(1'b1, 32'h0000_4104, 32'h200, 1'b0, 1'b0);
        step(1'b1, 32'h0000_4505, 32'h204, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0001, 32'h208, 1'b0, 1'b1);
        check_eq("fl_valid", {31'b0, out_valid}, 32'd0);
        check_eq("fl_ready", {31'b0, in_ready}, 32'd1);
        check_eq("fl_hold_pc", pc_out, 32'h200);
        step(1'b1, 32'h0000_4104, 32'h300, 1'b0, 1'b0);
        step(1'b1, 32'h0000_4505, 32'h304, 1'b1, 1'b1);
        check_eq("fl1_valid", {31'b0, out_valid}, 32'd0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            r = $urandom;
            if ($urandom_range(0, 3) == 0) r[1:0] = 2'b11;
            else r[1:0] = 2'($urandom_range(0, 2));
            step(($urandom_range(0, 3) != 0), r, $urandom,
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
        end

        // Reset asserted with the buffer full
        step(1'b1, 32'h0000_4104, 32'h400, 1'b0, 1'b0);
        step(1'b1, 32'h0000_4505, 32'h404, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        check_eq("mrst_valid", {31'b0, out_valid}, 32'd0);
        check_eq("mrst_ready", {31'b0, in_ready}, 32'd1);
        check_eq("mrst_inst", inst_out, 32'h0000_0013);
        in_valid = 1'b0;
        q.delete();
        shown = reset_entry();
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 32'h0000_4104, 32'h500, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/c_expand_stage.md
Name: c_expand_stage

Overview:
- Fetch-to-decode pipeline stage directly downstream of the compressed-misalignment aligner.
- Takes one aligned instruction per transfer. The low 16 bits hold an RVC instruction, or the full 32 bits hold a base instruction.
- Expands RV32C encodings to their RV32I equivalents and registers the result with PC, compressed flag and illegal flag for the decoder.
- Provides a valid/ready handshake with a 2-entry skid buffer, so in_ready is a registered signal, plus a branch flush.

Parameters:
- XLEN, 32, instruction and PC width.
- RESET_PC, 32'h0000_0000, value pc_out holds after reset.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  branch taken (sel_for_branch); discards all buffered entries.
- in_valid  input  1  aligner presents an instruction.
- in_ready  output  1  stage can accept; registered.
- inst_in  input  XLEN  aligned instruction; if [1:0]!=2'b11 only [15:0] is meaningful.
- pc_in  input  XLEN  PC of inst_in.
- out_valid  output  1  expanded instruction available.
- out_ready  input  1  decoder accepts.
- inst_out  output  XLEN  expanded instruction.
- pc_out  output  XLEN  PC of inst_out.
- is_compressed_o  output  1  source was 16-bit; next PC is +2.
- illegal_o  output  1  reserved or illegal RVC encoding.

Behaviour:
- Reset (reset=0, asynchronous):
  - out_valid=0, in_ready=1.
  - inst_out=32'h0000_0013 (nop), pc_out=RESET_PC, is_compressed_o=0, illegal_o=0.
  - Skid count=0.
- Expansion:
  - Purely combinational on inst_in; the result is captured at the input transfer (in_valid & in_ready).
  - Latency: one cycle from input transfer to out_valid when the buffer is empty.
- Expansion rules:
  - [1:0]==2'b11: inst_out=inst_in, is_compressed_o=0.
  - Quadrants 00/01/10: full RV32C set (C.ADDI4SPN, LW, SW, NOP, ADDI, JAL, LI, ADDI16SP, LUI, SRLI, SRAI, ANDI, SUB, XOR, OR, AND, J, BEQZ, BNEZ, SLLI, LWSP, JR, MV, EBREAK, JALR, ADD, SWSP).
  - Compressed register fields rd'/rs1'/rs2' map to x8+field.
  - Immediates are sign- or zero-extended per the ISA.
- Illegal encodings set illegal_o=1 with inst_out={16'h0, inst_in[15:0]}:
  - 16'h0000.
  - ADDI4SPN with imm=0.
  - LWSP with rd=0.
  - JR with rs1=0.
  - ADDI16SP/LUI with imm=0.
  - Shifts with shamt[5]=1.
  - FP loads/stores (C.FLD, C.FLW, C.FSD, C.FSW, and the SP forms).
- Hint encodings (e.g. C.NOP with imm!=0, C.LI rd=0) expand normally and are not illegal.
- Skid buffer:
  - Entries 0 (output register) and 1 (skid).
  - Count 0..2; in_ready = (count<2) as registered for the next cycle.
  - Transfer out on out_valid & out_ready.
  - Simultaneous in and out transfers with count==1: output register refills; count stays 1.
  - When count==2, an output transfer moves skid to output and in_ready rises the next cycle.
  - Ordering is strict FIFO; no entry is duplicated or dropped.
- Flush:
  - Synchronous, highest priority.
  - Next cycle: count=0, out_valid=0, in_ready=1.
  - Any in_valid in the flush cycle is discarded.
  - Data outputs hold their last values.
- Outputs are stable while out_valid=1 and out_ready=0.
- Reset asserted mid-transfer returns the stage to the reset values immediately; no partial entry survives.

Decomposition:
- Package c_pkg:
  - opcode constants (OP_LOAD, OP_STORE, OP_IMM, OP_LUI, OP_BRANCH, OP_JAL, OP_JALR, OP_OP, OP_SYSTEM).
  - RVC quadrant/funct3 constants.
  - NOP constant 32'h0000_0013.
  - Packed struct fetch_entry_t {inst, pc, is_compressed, illegal}.
- Sub-module c_expander: combinational 16-to-32 expansion, outputs inst and illegal.
- c_expand_stage instantiates c_expander and owns the skid buffer and handshake.

Test Plan:
- Reset then inst_in=32'h0000_4104 (C.LW x9,0(x10)), pc_in=0, out_ready=1 -> next cycle out_valid=1, inst_out=32'h0005_2483, is_compressed_o=1, illegal_o=0.
- inst_in=32'h0000_4505 (C.LI x10,1) -> inst_out=32'h0010_0513; inst_in=32'h0000_0001 (C.NOP) -> 32'h0000_0013.
- inst_in=32'h0050_0093 (addi x1,x0,5) -> inst_out=32'h0050_0093, is_compressed_o=0.
- inst_in=32'h0000_0000 -> illegal_o=1, inst_out=32'h0000_0000, out_valid=1.
- out_ready=0 with three back-to-back inputs -> first two accepted, in_ready=0 on the third, which is held. Then out_ready=1 -> outputs appear in order with unchanged pc_out, and in_ready returns to 1 the cycle after the first drain.
- Count=2 then flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, flush-cycle input discarded. Also assert reset mid-stream -> out_valid=0 immediately.
